// File: rtl/vga_timing_pkg.sv
// Shared VGA scan types, standard timing sets and the sync-window decode helper.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;

  // 640x480 @ 60 Hz, 25.175 MHz nominal pixel clock (25 MHz in practice)
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // 1920x1080 @ 60 Hz, 148.5 MHz pixel clock
  localparam int HD_H_ACTIVE  = 1920;
  localparam int HD_H_FP      = 88;
  localparam int HD_H_SYNC    = 44;
  localparam int HD_H_BP      = 148;
  localparam int HD_V_ACTIVE  = 1080;
  localparam int HD_V_FP      = 4;
  localparam int HD_V_SYNC    = 5;
  localparam int HD_V_BP      = 36;

  // True when first <= v < first+len. Written as a difference so the upper
  // bound never has to be represented (it may equal the line/frame total).
  function automatic logic in_window(input int unsigned v,
                                     input int unsigned first,
                                     input int unsigned len);
    return (len != 0) && (v >= first) && ((v - first) < len);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Column/line counter for a raster scan; both counters advance only on i_en.
module raster_counter #(
  parameter  int H_TOTAL = 800,
  parameter  int V_TOTAL = 525,
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          i_en,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_x_last,
  output logic          o_y_last
);

  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          w_x_last;
  logic          w_y_last;

  assign w_x_last = (r_x == X_LAST);
  assign w_y_last = (r_y == Y_LAST);

  // Step x every enabled cycle; y only moves when x wraps, and the whole raster wraps together.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_en) begin
      if (w_x_last) begin
        r_x <= '0;
        r_y <= w_y_last ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_x_last = w_x_last;
  assign o_y_last = w_y_last;

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: run/drain/idle sequencing, pixel prescaler and timing decode.
// A stop request always lets the current frame complete before going idle.
module vga_scan_ctrl
  import vga_timing_pkg::*;
#(
  parameter  int H_ACTIVE       = VGA_H_ACTIVE,
  parameter  int H_FP           = VGA_H_FP,
  parameter  int H_SYNC         = VGA_H_SYNC,
  parameter  int H_BP           = VGA_H_BP,
  parameter  int V_ACTIVE       = VGA_V_ACTIVE,
  parameter  int V_FP           = VGA_V_FP,
  parameter  int V_SYNC         = VGA_V_SYNC,
  parameter  int V_BP           = VGA_V_BP,
  parameter  int CLKS_PER_PIXEL = 4,
  parameter  bit SYNC_POL       = 1'b0,
  localparam int H_TOTAL        = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL        = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW             = $clog2(H_TOTAL),
  localparam int YW             = $clog2(V_TOTAL)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          run,
  output logic          pix_en,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic          line_start,
  output logic          frame_start,
  output logic          busy
);

  // Prescaler needs at least one bit even when every clock is a pixel.
  localparam int            PW         = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_PIXEL - 1);

  if (H_TOTAL < 2 || V_TOTAL < 2 || CLKS_PER_PIXEL < 1) begin : g_bad_params
    $error("vga_scan_ctrl: H_TOTAL and V_TOTAL must be >= 2, CLKS_PER_PIXEL >= 1");
  end

  scan_state_t   r_state;
  logic [PW-1:0] r_presc;
  logic          w_busy;
  logic          w_pix_en;
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic          w_x_last;
  logic          w_y_last;
  logic          w_frame_end;
  logic          w_hs_win;
  logic          w_vs_win;
  logic          w_line_start;

  assign w_busy      = (r_state != IDLE);
  assign w_pix_en    = w_busy && (r_presc == PRESC_LAST);
  assign w_frame_end = w_pix_en && w_x_last && w_y_last;

  // Divide the system clock down to the pixel rate; parked at 0 while idle so a
  // fresh start always gives pixel (0,0) a full pixel period.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (!w_busy || r_presc == PRESC_LAST) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Run/stop sequencing: a stop only takes effect at the end of the frame, and
  // re-asserting run while draining simply resumes without disturbing the raster.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (run) r_state <= SCAN;
        SCAN:    if (!run) r_state <= DRAIN;
        DRAIN: begin
          if (run)              r_state <= SCAN;
          else if (w_frame_end) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  raster_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_raster (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_en     (w_pix_en),
    .o_x      (w_x),
    .o_y      (w_y),
    .o_x_last (w_x_last),
    .o_y_last (w_y_last)
  );

  assign w_hs_win     = in_window(32'(w_x), H_ACTIVE + H_FP, H_SYNC);
  assign w_vs_win     = in_window(32'(w_y), V_ACTIVE + V_FP, V_SYNC);
  assign w_line_start = w_pix_en && (w_x == '0);

  assign pix_en      = w_pix_en;
  assign x           = w_x;
  assign y           = w_y;
  assign hsync       = w_hs_win ? SYNC_POL : !SYNC_POL;
  assign vsync       = w_vs_win ? SYNC_POL : !SYNC_POL;
  assign active      = w_busy && (32'(w_x) < H_ACTIVE) && (32'(w_y) < V_ACTIVE);
  assign line_start  = w_line_start;
  assign frame_start = w_line_start && (w_y == '0);
  assign busy        = w_busy;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl on a tiny 8x6 raster at 2 clocks per pixel.
// Every cycle the stimulus side pushes the expected output word into a queue;
// a monitor on the falling edge pops and compares it with the DUT outputs.
module tb_vga_scan_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       run = 1'b0;
  logic       pix_en;
  logic [2:0] x;
  logic [2:0] y;
  logic       hsync;
  logic       vsync;
  logic       active;
  logic       line_start;
  logic       frame_start;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Expected output word: {pix_en, x, y, hsync, vsync, active, line_start, frame_start, busy}
  logic [12:0] exp_q[$];

  // Reference: state (0 idle, 1 scan, 2 drain), pixel phase, linear pixel index 0..47
  int m_st = 0;
  int m_ph = 0;
  int m_p  = 0;

  always #5 clock = ~clock;

  vga_scan_ctrl #(
    .H_ACTIVE       (4),
    .H_FP           (1),
    .H_SYNC         (2),
    .H_BP           (1),
    .V_ACTIVE       (3),
    .V_FP           (1),
    .V_SYNC         (1),
    .V_BP           (1),
    .CLKS_PER_PIXEL (2),
    .SYNC_POL       (1'b0)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .run         (run),
    .pix_en      (pix_en),
    .x           (x),
    .y           (y),
    .hsync       (hsync),
    .vsync       (vsync),
    .active      (active),
    .line_start  (line_start),
    .frame_start (frame_start),
    .busy        (busy)
  );

  // Monitor: compare the DUT against the oldest pending expectation.
  always @(negedge clock) begin
    logic [12:0] e;
    logic [12:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {pix_en, x, y, hsync, vsync, active, line_start, frame_start, busy};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs t=%0t actual={pe,x,y,hs,vs,act,ls,fs,busy}=%b_%0d_%0d_%b%b%b%b%b%b required=%b_%0d_%0d_%b%b%b%b%b%b",
                 $time, a[12], a[11:9], a[8:6], a[5], a[4], a[3], a[2], a[1], a[0],
                 e[12], e[11:9], e[8:6], e[5], e[4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // One clock: advance the reference with the inputs present at the edge, then queue its outputs.
  task automatic tick();
    logic rn, rr, pe, last, bz, hs, vs, act, ls, fs;
    int ox, oy;
    rn = reset_n;
    rr = run;
    @(posedge clock);
    #1;
    cyc++;
    if (!rn) begin
      m_st = 0;
      m_ph = 0;
      m_p  = 0;
    end else begin
      pe   = (m_st != 0) && (m_ph == 1);
      last = pe && (m_p == 47);
      if (pe) m_p = (m_p + 1) % 48;
      m_ph = (m_st != 0) ? (1 - m_ph) : 0;
      case (m_st)
        0:       if (rr) m_st = 1;
        1:       if (!rr) m_st = 2;
        default: if (rr) m_st = 1; else if (last) m_st = 0;
      endcase
    end
    bz  = (m_st != 0);
    pe  = bz && (m_ph == 1);
    ox  = m_p % 8;
    oy  = m_p / 8;
    hs  = !(ox == 5 || ox == 6);
    vs  = !(oy == 4);
    act = bz && (ox < 4) && (oy < 3);
    ls  = pe && (ox == 0);
    fs  = ls && (oy == 0);
    exp_q.push_back({pe, 3'(ox), 3'(oy), hs, vs, act, ls, fs, bz});
  endtask

  initial begin
    int c0, first_pe, fs1, fs2, vlow, lcnt, cnt, n, prev_fs, ival, cr;

    // 1: reset, then idle with run low
    reset_n = 1'b0;
    run     = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy || pix_en || active || !hsync || !vsync || x != 3'd0 || y != 3'd0) cnt++;
    end
    chk("idle_quiet_cycles", cnt, 0);

    // 2/3: start scanning, measure first pixel, frame period, vsync width, lines per frame
    run = 1'b1;
    c0 = cyc; first_pe = -1; fs1 = -1; fs2 = -1; vlow = 0; lcnt = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (pix_en && first_pe < 0) first_pe = cyc;
      if (frame_start) begin
        if (fs1 < 0) fs1 = cyc;
        else if (fs2 < 0) fs2 = cyc;
      end
      if (fs1 >= 0 && fs2 < 0) begin
        if (!vsync) vlow++;
        if (line_start) lcnt++;
      end
    end
    chk("first_pix_en_delay", first_pe - c0, 2);
    chk("first_frame_start_delay", fs1 - c0, 2);
    chk("frame_period_clk", fs2 - fs1, 96);
    chk("vsync_low_clk", vlow, 16);
    chk("lines_per_frame", lcnt, 6);

    // 4: stop at the start of pixel (2,1); frame must finish, then idle at (0,0)
    n = 0;
    while (!(m_p == 10 && m_ph == 0) && n < 200) begin tick(); n++; end
    chk("reach_x2y1_in_budget", int'(n < 200), 1);
    chk("stop_point_x", int'(x), 2);
    chk("stop_point_y", int'(y), 1);
    run = 1'b0;
    n = 0;
    while (busy && n < 300) begin tick(); n++; end
    chk("drain_clk_to_idle", n, 76);
    chk("idle_x", int'(x), 0);
    chk("idle_y", int'(y), 0);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (frame_start || pix_en || busy) cnt++;
    end
    chk("no_activity_after_drain", cnt, 0);

    // 5: restart, drop run mid-frame, raise it again before the end: continuous scan
    run = 1'b1;
    n = 0;
    while (!(m_p == 20 && m_ph == 0) && n < 300) begin tick(); n++; end
    chk("reach_pixel20_in_budget", int'(n < 300), 1);
    run = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (!busy) cnt++; end
    run = 1'b1;
    prev_fs = -1; ival = -1;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (!busy) cnt++;
      if (frame_start) begin
        if (prev_fs >= 0 && ival < 0) ival = cyc - prev_fs;
        prev_fs = cyc;
      end
    end
    chk("no_idle_during_resume", cnt, 0);
    chk("resumed_frame_period_clk", ival, 96);

    // 6: reset pulse at (6,4) with run held high
    n = 0;
    while (!(m_p == 38 && m_ph == 0) && n < 200) begin tick(); n++; end
    chk("reset_point_x", int'(x), 6);
    chk("reset_point_y", int'(y), 4);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    cr = cyc;
    chk("post_reset_x", int'(x), 0);
    chk("post_reset_y", int'(y), 0);
    chk("post_reset_busy", int'(busy), 0);
    chk("post_reset_hsync", int'(hsync), 1);
    chk("post_reset_vsync", int'(vsync), 1);
    first_pe = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pix_en && first_pe < 0) first_pe = cyc;
    end
    chk("post_reset_first_pix_en", first_pe - cr, 2);
    for (int i = 0; i < 20; i++) tick();

    #10;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
